// File: rtl/sync_updown_counter_n.sv
// Parametrised synchronous up/down counter with count enable, parallel load,
// modulo-N terminal value, wrap/saturate mode, terminal-count output and
// sticky overflow flag. Only the reset (clear) is asynchronous.
//
// q is declared [0:WIDTH-1] so that q[0] is the MSB. The internal count is kept
// as a conventional [WIDTH-1:0] vector; assignment between the two is
// positional, so the numeric value is preserved.
//
// Cascading: connect tc of one stage to en of the next. tc is asserted in the
// cycle before a boundary event, so the next stage steps on the same edge.
module sync_updown_counter_n #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ovf_clr,
  output logic [0:WIDTH-1] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CountOne = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q;
  logic             ovf_q;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count_q == MAX_COUNT);
  assign at_zero = (count_q == '0);

  // Boundary event about to happen on the next edge; load masks it.
  assign tc = en & ~load & ((ud & at_max) | (~ud & at_zero));

  // Next count: load (with clamp) beats enable, enable beats hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (d > MAX_COUNT) ? MAX_COUNT : d;
    end else if (en) begin
      if (ud) begin
        if (!at_max) begin
          count_d = count_q + CountOne;
        end else if (!SATURATE) begin
          count_d = '0;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - CountOne;
        end else if (!SATURATE) begin
          count_d = MAX_COUNT;
        end
      end
    end
  end

  // All state: count, wrap pulse (registered tc) and sticky ovf, where a set
  // on the same edge as a clear wins so no boundary event is lost.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= tc;
      if (tc) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr || load) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sync_updown_counter_n.sv
// Directed-vector bench for sync_updown_counter_n. Three instances share one
// stimulus stream: A = 4-bit mod-10 wrap, B = 4-bit mod-10 saturate,
// C = 8-bit full range wrap. Each vector names the instance it checks.
module tb_sync_updown_counter_n;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       en = 1'b0;
  logic       ud = 1'b0;
  logic       load = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] d = 8'd0;

  logic [0:3] q_a, q_b;
  logic [0:7] q_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       ovf_a, ovf_b, ovf_c;

  always #5 clk = ~clk;

  sync_updown_counter_n #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b0)) u_a (
    .clk(clk), .clear(clear), .en(en), .ud(ud), .load(load), .d(d[3:0]),
    .ovf_clr(ovf_clr), .q(q_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
  );

  sync_updown_counter_n #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)) u_b (
    .clk(clk), .clear(clear), .en(en), .ud(ud), .load(load), .d(d[3:0]),
    .ovf_clr(ovf_clr), .q(q_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
  );

  sync_updown_counter_n #(.WIDTH(8)) u_c (
    .clk(clk), .clear(clear), .en(en), .ud(ud), .load(load), .d(d),
    .ovf_clr(ovf_clr), .q(q_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c)
  );

  typedef struct {
    int         sel;
    string      name;
    logic       ld;
    logic       en;
    logic       ud;
    logic       oc;
    logic [7:0] d;
    logic       tc;   // expected just before the edge
    logic [7:0] q;    // expected after the edge
    logic       w;
    logic       o;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input int sel, input string name, input logic ld,
                              input logic e, input logic u, input logic oc,
                              input logic [7:0] dv, input logic etc,
                              input logic [7:0] eq, input logic ew, input logic eo);
    vec_t v;
    v.sel = sel; v.name = name; v.ld = ld; v.en = e; v.ud = u; v.oc = oc;
    v.d = dv; v.tc = etc; v.q = eq; v.w = ew; v.o = eo;
    return v;
  endfunction

  task automatic pick(input int sel, output logic [7:0] gq, output logic gtc,
                      output logic gw, output logic go);
    case (sel)
      0:       begin gq = {4'b0, q_a}; gtc = tc_a; gw = wrap_a; go = ovf_a; end
      1:       begin gq = {4'b0, q_b}; gtc = tc_b; gw = wrap_b; go = ovf_b; end
      default: begin gq = q_c;         gtc = tc_c; gw = wrap_c; go = ovf_c; end
    endcase
  endtask

  task automatic check(input string name, input string field, input logic [7:0] got,
                       input logic [7:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s %s: got %0d, required %0d", name, field, got, exp);
    end
  endtask

  task automatic step(input vec_t v);
    logic [7:0] gq;
    logic       gtc, gw, go;
    load = v.ld; en = v.en; ud = v.ud; ovf_clr = v.oc; d = v.d;
    @(negedge clk);
    pick(v.sel, gq, gtc, gw, go);
    check(v.name, "tc", {7'b0, gtc}, {7'b0, v.tc});
    @(posedge clk);
    #1;
    pick(v.sel, gq, gtc, gw, go);
    check(v.name, "q", gq, v.q);
    check(v.name, "wrap", {7'b0, gw}, {7'b0, v.w});
    check(v.name, "ovf", {7'b0, go}, {7'b0, v.o});
  endtask

  initial begin
    // Test 2: modulo up-wrap (A)
    vecs.push_back(mk(0, "t2 load8", 1, 0, 1, 0, 8'd8, 0, 8'd8, 0, 0));
    vecs.push_back(mk(0, "t2 up9",   0, 1, 1, 0, 8'd0, 0, 8'd9, 0, 0));
    vecs.push_back(mk(0, "t2 wrap0", 0, 1, 1, 0, 8'd0, 1, 8'd0, 1, 1));
    vecs.push_back(mk(0, "t2 up1",   0, 1, 1, 0, 8'd0, 0, 8'd1, 0, 1));
    // Test 3: down-wrap and reversal (A)
    vecs.push_back(mk(0, "t3 load1", 1, 0, 0, 0, 8'd1, 0, 8'd1, 0, 0));
    vecs.push_back(mk(0, "t3 dn0",   0, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0));
    vecs.push_back(mk(0, "t3 dn9",   0, 1, 0, 0, 8'd0, 1, 8'd9, 1, 1));
    vecs.push_back(mk(0, "t3 rev0",  0, 1, 1, 0, 8'd0, 1, 8'd0, 1, 1));
    vecs.push_back(mk(0, "t3 hold",  0, 0, 1, 0, 8'd0, 0, 8'd0, 0, 1));
    // Test 4: saturate (B)
    vecs.push_back(mk(1, "t4 load0", 1, 0, 0, 0, 8'd0, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, "t4 sat1",  0, 1, 0, 0, 8'd0, 1, 8'd0, 1, 1));
    vecs.push_back(mk(1, "t4 sat2",  0, 1, 0, 0, 8'd0, 1, 8'd0, 1, 1));
    vecs.push_back(mk(1, "t4 sat3",  0, 1, 0, 0, 8'd0, 1, 8'd0, 1, 1));
    vecs.push_back(mk(1, "t4 oclr",  0, 0, 0, 1, 8'd0, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, "t4 idle",  0, 0, 0, 0, 8'd0, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, "t4 load9", 1, 0, 1, 0, 8'd9, 0, 8'd9, 0, 0));
    vecs.push_back(mk(1, "t4 sattop", 0, 1, 1, 0, 8'd0, 1, 8'd9, 1, 1));
    // Test 5: load priority and clamp (A)
    vecs.push_back(mk(0, "t5 clamp", 1, 1, 1, 0, 8'h0F, 0, 8'd9, 0, 0));
    vecs.push_back(mk(0, "t5 ldpri", 1, 1, 1, 0, 8'd3, 0, 8'd3, 0, 0));
    vecs.push_back(mk(0, "t5 up4",   0, 1, 1, 0, 8'd0, 0, 8'd4, 0, 0));
    // Test 6: full width (C)
    vecs.push_back(mk(2, "t6 ld250", 1, 0, 1, 0, 8'd250, 0, 8'd250, 0, 0));
    for (int k = 1; k <= 10; k++) begin
      vecs.push_back(mk(2, $sformatf("t6 up%0d", k), 0, 1, 1, 0, 8'd0, (k == 6),
                        8'((250 + k) % 256), (k == 6), (k >= 6)));
    end
    for (int k = 1; k <= 5; k++) begin
      vecs.push_back(mk(2, $sformatf("t6 hold%0d", k), 0, 0, 1, 0, 8'd0, 0, 8'd4, 0, 1));
    end
    vecs.push_back(mk(2, "t6 ld255", 1, 0, 1, 0, 8'd255, 0, 8'd255, 0, 0));
    vecs.push_back(mk(2, "t6 coll",  0, 1, 1, 1, 8'd0, 1, 8'd0, 1, 1));
    vecs.push_back(mk(2, "t6 oclr",  0, 0, 1, 1, 8'd0, 0, 8'd0, 0, 0));

    // Test 1: async reset, including mid-count reset between edges
    #3 clear = 1'b0;
    #1;
    check("t1 por", "q_a", {4'b0, q_a}, 8'd0);
    check("t1 por", "q_c", q_c, 8'd0);
    check("t1 por", "ovf_a", {7'b0, ovf_a}, 8'd0);
    check("t1 por", "wrap_a", {7'b0, wrap_a}, 8'd0);
    #7 clear = 1'b1;
    step(mk(0, "t1 load9", 1, 0, 1, 0, 8'd9, 0, 8'd9, 0, 0));
    step(mk(0, "t1 wrap",  0, 1, 1, 0, 8'd0, 1, 8'd0, 1, 1));
    for (int k = 1; k <= 5; k++) begin
      step(mk(0, $sformatf("t1 up%0d", k), 0, 1, 1, 0, 8'd0, 0, 8'(k), 0, 1));
    end
    #1 clear = 1'b0;
    #1;
    check("t1 midclr", "q_a", {4'b0, q_a}, 8'd0);
    check("t1 midclr", "ovf_a", {7'b0, ovf_a}, 8'd0);
    check("t1 midclr", "wrap_a", {7'b0, wrap_a}, 8'd0);
    clear = 1'b1;
    step(mk(0, "t1 first", 0, 1, 1, 0, 8'd0, 0, 8'd1, 0, 0));

    foreach (vecs[i]) step(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
